// File: rtl/apb_mem_slave.sv
// APB memory slave: single-port word memory behind an IDLE/ACCESS handshake with WAIT_CYCLES wait states.
// Optional byte-lane write strobes are enabled by defining APB_MEM_STRB_EN.
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_MEM_STRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int LANES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_addr;
  logic              misaligned;
  logic              out_of_range;
  logic              xfer_err;
  logic [LANES-1:0]  wr_strb;
  logic              mem_we;

  assign word_idx     = paddr[ADDR_W-1:OFF_W];
  assign mem_addr     = word_idx[MEM_AW-1:0];
  assign out_of_range = ({1'b0, word_idx} >= (IDX_W+1)'(DEPTH));
  assign xfer_err     = out_of_range | misaligned;

  generate
    if (OFF_W > 0) begin : g_off
      assign misaligned = |paddr[OFF_W-1:0];
    end else begin : g_no_off
      assign misaligned = 1'b0;
    end
  endgenerate

`ifdef APB_MEM_STRB_EN
  assign wr_strb = pstrb;
`else
  assign wr_strb = '1;
`endif

  // pready, pslverr and prdata are computed one cycle ahead so they leave flops;
  // the APB address/control stay stable across the transfer, so the early sample is valid.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pready_d = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d  = ACCESS;
          cnt_d    = WAIT_INIT;
          pready_d = (WAIT_INIT == 4'd0);
        end
      end
      ACCESS: begin
        if (!psel || pready_q) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          mem_we  = psel && penable && pready_q && pwrite && !xfer_err;
        end else if (penable && (cnt_q != 4'd0)) begin
          cnt_d    = cnt_q - 4'd1;
          pready_d = (cnt_q == 4'd1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    pslverr_d = pready_d && xfer_err;
    prdata_d  = (pready_d && !pwrite && !xfer_err) ? mem[mem_addr] : '0;
  end

  // Memory has no reset; a zero strobe mask still completes the write handshake.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_strb[i]) mem[mem_addr][i*8 +: 8] <= pwdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: a zero-wait and a three-wait instance, vector table, corner sequences
// and random transfers checked against an array model of the memory.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  psel = '0;
  logic [1:0]  penable = '0;
  logic [1:0]  pwrite = '0;
  logic [11:0] paddr [2];
  logic [31:0] pwdata [2];
`ifdef APB_MEM_STRB_EN
  logic [3:0]  pstrb [2];
`endif
  logic [1:0]  pready;
  logic [1:0]  pslverr;
  logic [31:0] prdata [2];

  int total = 0;
  int bad = 0;

  logic [31:0] model_mem [2][64];
  bit          model_vld [2][64];

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs [13];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    apb_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_CYCLES(gi * 3)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .psel   (psel[gi]),
      .penable(penable[gi]),
      .pwrite (pwrite[gi]),
      .paddr  (paddr[gi]),
      .pwdata (pwdata[gi]),
`ifdef APB_MEM_STRB_EN
      .pstrb  (pstrb[gi]),
`endif
      .pready (pready[gi]),
      .prdata (prdata[gi]),
      .pslverr(pslverr[gi])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_write(input int b, input int idx, input logic [31:0] wd, input logic [3:0] st);
    logic [3:0] eff;
`ifdef APB_MEM_STRB_EN
    eff = st;
`else
    eff = st | 4'hF;
`endif
    for (int i = 0; i < 4; i++) if (eff[i]) model_mem[b][idx][i*8 +: 8] = wd[i*8 +: 8];
    if (eff == 4'hF) model_vld[b][idx] = 1'b1;
  endtask

  // One full transfer with an idle cycle after; waits counts access cycles with pready low.
  task automatic xfer(input int b, input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output int waits, output bit tmo, output logic after);
    @(posedge clk); #1;
    psel[b] = 1'b1; penable[b] = 1'b0; pwrite[b] = wr; paddr[b] = addr; pwdata[b] = wd;
`ifdef APB_MEM_STRB_EN
    pstrb[b] = st;
`endif
    @(posedge clk); #1;
    penable[b] = 1'b1;
    waits = 0;
    tmo = 1'b0;
    @(negedge clk);
    while (!pready[b] && !tmo) begin
      waits++;
      if (waits > 40) tmo = 1'b1;
      else @(negedge clk);
    end
    rd = prdata[b];
    er = pslverr[b];
    @(posedge clk); #1;
    psel[b] = 1'b0; penable[b] = 1'b0;
    @(negedge clk);
    after = pready[b];
  endtask

  task automatic check_xfer(input string tag, input int b, input bit wr, input logic [11:0] addr,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd, output logic er);
    int idx;
    int waits;
    bit tmo;
    logic after;
    bit exp_err;
    bit known;
    logic [31:0] exp_rd;
    idx = int'(addr[11:2]);
    exp_err = (idx >= 64) || (addr[1:0] != 2'b00);
    known = !exp_err && !wr && model_vld[b][idx];
    exp_rd = known ? model_mem[b][idx] : 32'h0;
    xfer(b, wr, addr, wd, st, rd, er, waits, tmo, after);
    $display("[%s] inst%0d %s addr=%h wdata=%h strb=%h rdata=%h err=%0d waits=%0d",
             tag, b, wr ? "WR" : "RD", addr, wd, st, rd, er, waits);
    chk({tag, " timeout"}, 32'(tmo), 32'd0);
    chk({tag, " pslverr"}, 32'(er), 32'(exp_err));
    chk({tag, " waits"}, waits, b * 3);
    chk({tag, " pready width"}, 32'(after), 32'd0);
    if (wr || exp_err || known) chk({tag, " prdata"}, rd, exp_rd);
    if (wr && !exp_err) model_write(b, idx, wd, st);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int to;

    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 12'h000, 32'h0BADF00D, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 12'h100, 32'h12345678, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 12'h002, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b0, 12'h000, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[6]  = '{1'b1, 12'h0FC, 32'h5A5A0001, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 12'h0FC, 32'h0,        32'h5A5A0001, 1'b0};
    vecs[8]  = '{1'b0, 12'h0FD, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b0, 12'h104, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 12'h001, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 12'h000, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[12] = '{1'b1, 12'h3FC, 32'h77777777, 32'h0,        1'b1};

    for (int b = 0; b < 2; b++) begin
      paddr[b] = '0; pwdata[b] = '0;
`ifdef APB_MEM_STRB_EN
      pstrb[b] = '0;
`endif
      for (int i = 0; i < 64; i++) model_vld[b][i] = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("reset pready%0d", b), 32'(pready[b]), 32'd0);
      chk($sformatf("reset pslverr%0d", b), 32'(pslverr[b]), 32'd0);
      chk($sformatf("reset prdata%0d", b), prdata[b], 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Vector table on both wait configurations
    for (int b = 0; b < 2; b++) begin
      for (int v = 0; v < 13; v++) begin
        check_xfer($sformatf("vec%0d", v), b, vecs[v].wr, vecs[v].addr, vecs[v].wdata, 4'hF, rd, er);
        chk($sformatf("vec%0d table rdata", v), rd, vecs[v].exp_rdata);
        chk($sformatf("vec%0d table err", v), 32'(er), 32'(vecs[v].exp_err));
      end
    end

    // Back-to-back write then read with no idle cycle (zero-wait instance)
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 12'h008; pwdata[0] = 32'h0B2B0B2B;
`ifdef APB_MEM_STRB_EN
    pstrb[0] = 4'hF;
`endif
    @(posedge clk); #1 penable[0] = 1'b1;
    @(negedge clk);
    chk("b2b write pready", 32'(pready[0]), 32'd1);
    chk("b2b write pslverr", 32'(pslverr[0]), 32'd0);
    @(posedge clk); #1 penable[0] = 1'b0; pwrite[0] = 1'b0;
    @(negedge clk);
    chk("b2b setup pready", 32'(pready[0]), 32'd0);
    @(posedge clk); #1 penable[0] = 1'b1;
    @(negedge clk);
    chk("b2b read pready", 32'(pready[0]), 32'd1);
    chk("b2b read prdata", prdata[0], 32'h0B2B0B2B);
    @(posedge clk); #1 psel[0] = 1'b0; penable[0] = 1'b0;
    model_write(0, 2, 32'h0B2B0B2B, 4'hF);
    $display("[b2b] inst0 WR/RD addr=008 data=0b2b0b2b");

`ifdef APB_MEM_STRB_EN
    check_xfer("strb full", 0, 1'b1, 12'h020, 32'h11223344, 4'hF, rd, er);
    check_xfer("strb 0101", 0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, rd, er);
    check_xfer("strb read", 0, 1'b0, 12'h020, 32'h0, 4'h0, rd, er);
    chk("strb merged value", rd, 32'h11BB33DD);
    check_xfer("strb none", 0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, rd, er);
    check_xfer("strb reread", 0, 1'b0, 12'h020, 32'h0, 4'hF, rd, er);
    chk("strb none value", rd, 32'h11BB33DD);
`endif

    // Abort: psel dropped in the second access cycle of a 3-wait write
    check_xfer("abort pre", 1, 1'b1, 12'h030, 32'h13579BDF, 4'hF, rd, er);
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h030; pwdata[1] = 32'hCAFEF00D;
`ifdef APB_MEM_STRB_EN
    pstrb[1] = 4'hF;
`endif
    @(posedge clk); #1 penable[1] = 1'b1;
    @(negedge clk);
    chk("abort access1 pready", 32'(pready[1]), 32'd0);
    @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("abort pready c%0d", i), 32'(pready[1]), 32'd0);
    end
    $display("[abort] inst1 WR addr=030 data=cafef00d dropped");
    check_xfer("abort post", 1, 1'b0, 12'h030, 32'h0, 4'hF, rd, er);
    chk("abort old data", rd, 32'h13579BDF);

    // Reset asserted in the pready cycle of a write: outputs clear at once, no write lands
    check_xfer("rst pre", 1, 1'b1, 12'h044, 32'h44440000, 4'hF, rd, er);
    check_xfer("rst read pre", 1, 1'b0, 12'h010, 32'h0, 4'hF, rd, er);
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h044; pwdata[1] = 32'h99999999;
    @(posedge clk); #1 penable[1] = 1'b1;
    to = 0;
    @(negedge clk);
    while (!pready[1] && to < 40) begin
      to++;
      @(negedge clk);
    end
    chk("rst pready reached", 32'(pready[1]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst async pready", 32'(pready[1]), 32'd0);
    chk("rst async pslverr", 32'(pslverr[1]), 32'd0);
    chk("rst async prdata", prdata[1], 32'd0);
    @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    $display("[reset] inst1 WR addr=044 data=99999999 aborted by reset");
    check_xfer("rst post", 1, 1'b0, 12'h044, 32'h0, 4'hF, rd, er);
    chk("rst no write", rd, 32'h44440000);

    // Random transfers against the model
    for (int n = 0; n < 200; n++) begin
      int b;
      int r;
      bit wr;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [3:0] st;
      b = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 7) addr = {4'h0, 6'($urandom_range(0, 63)), 2'b00};
      else if (r == 7) addr = {4'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else addr = {10'($urandom_range(64, 1023)), 2'b00};
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      check_xfer($sformatf("rnd%0d", n), b, wr, addr, wd, st, rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
